// File: rtl/spi_lcd_rx.sv
// SPI display-command receiver: oversamples a write-only 4-wire SPI link and
// decodes CASET/PASET/RAMWR into addressed RGB565 pixel writes.
module spi_lcd_rx #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sclk,
  input  logic        i_mosi,
  input  logic        i_cs_n,
  input  logic        i_dc,
  output logic [7:0]  o_byte,
  output logic        o_byte_dc,
  output logic        o_byte_valid,
  output logic [7:0]  o_cmd,
  output logic        o_cmd_valid,
  output logic [15:0] o_px_x,
  output logic [15:0] o_px_y,
  output logic [15:0] o_px_data,
  output logic        o_px_valid,
  output logic        o_err
);

  typedef enum logic [1:0] {S_IDLE, S_CASET, S_PASET, S_RAMWR} state_t;

  localparam logic [15:0] COL_LIMIT = 16'(WIDTH);
  localparam logic [15:0] ROW_LIMIT = 16'(HEIGHT);

  logic [1:0]  sclk_sync_reg, mosi_sync_reg, dc_sync_reg, cs_sync_reg;
  logic        sclk_prev_reg;
  logic [2:0]  bit_cnt_reg;
  logic [6:0]  shift_reg;

  state_t      state_reg;
  logic [1:0]  param_cnt_reg;
  logic [23:0] param_reg;
  logic [15:0] sc_reg, ec_reg, sp_reg, ep_reg;
  logic [15:0] cur_x_reg, cur_y_reg;
  logic        hi_pending_reg;
  logic [7:0]  hi_byte_reg;

  logic        sclk_rise;
  logic [15:0] new_start, new_end;

  assign sclk_rise = sclk_sync_reg[1] & ~sclk_prev_reg;
  // Fourth parameter byte completes the end address directly from o_byte
  assign new_start = param_reg[23:8];
  assign new_end   = {param_reg[7:0], o_byte};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sclk_sync_reg <= 2'b00;
      mosi_sync_reg <= 2'b00;
      dc_sync_reg   <= 2'b00;
      cs_sync_reg   <= 2'b11;
      sclk_prev_reg <= 1'b0;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 7'd0;
      o_byte        <= 8'd0;
      o_byte_dc     <= 1'b0;
      o_byte_valid  <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[0], i_sclk};
      mosi_sync_reg <= {mosi_sync_reg[0], i_mosi};
      dc_sync_reg   <= {dc_sync_reg[0], i_dc};
      cs_sync_reg   <= {cs_sync_reg[0], i_cs_n};
      sclk_prev_reg <= sclk_sync_reg[1];
      o_byte_valid  <= 1'b0;
      if (cs_sync_reg[1]) begin
        bit_cnt_reg <= 3'd0;
      end else if (sclk_rise) begin
        shift_reg <= {shift_reg[5:0], mosi_sync_reg[1]};
        if (bit_cnt_reg == 3'd7) begin
          o_byte       <= {shift_reg, mosi_sync_reg[1]};
          o_byte_dc    <= dc_sync_reg[1];
          o_byte_valid <= 1'b1;
          bit_cnt_reg  <= 3'd0;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg      <= S_IDLE;
      param_cnt_reg  <= 2'd0;
      param_reg      <= 24'd0;
      sc_reg         <= 16'd0;
      ec_reg         <= COL_LIMIT - 16'd1;
      sp_reg         <= 16'd0;
      ep_reg         <= ROW_LIMIT - 16'd1;
      cur_x_reg      <= 16'd0;
      cur_y_reg      <= 16'd0;
      hi_pending_reg <= 1'b0;
      hi_byte_reg    <= 8'd0;
      o_cmd          <= 8'd0;
      o_cmd_valid    <= 1'b0;
      o_px_x         <= 16'd0;
      o_px_y         <= 16'd0;
      o_px_data      <= 16'd0;
      o_px_valid     <= 1'b0;
      o_err          <= 1'b0;
    end else begin
      o_cmd_valid <= 1'b0;
      o_px_valid  <= 1'b0;
      o_err       <= 1'b0;
      if (o_byte_valid) begin
        if (!o_byte_dc) begin
          // Every command aborts the running sequence and rewinds the cursor
          o_cmd_valid    <= 1'b1;
          o_cmd          <= o_byte;
          param_cnt_reg  <= 2'd0;
          hi_pending_reg <= 1'b0;
          cur_x_reg      <= sc_reg;
          cur_y_reg      <= sp_reg;
          case (o_byte)
            8'h2A:   state_reg <= S_CASET;
            8'h2B:   state_reg <= S_PASET;
            8'h2C:   state_reg <= S_RAMWR;
            default: state_reg <= S_IDLE;
          endcase
        end else begin
          case (state_reg)
            S_CASET, S_PASET: begin
              if (param_cnt_reg == 2'd3) begin
                if (state_reg == S_CASET) begin
                  if (new_start <= new_end && new_end < COL_LIMIT) begin
                    sc_reg <= new_start;
                    ec_reg <= new_end;
                  end else begin
                    o_err <= 1'b1;
                  end
                end else begin
                  if (new_start <= new_end && new_end < ROW_LIMIT) begin
                    sp_reg <= new_start;
                    ep_reg <= new_end;
                  end else begin
                    o_err <= 1'b1;
                  end
                end
                state_reg <= S_IDLE;
              end else begin
                param_reg     <= {param_reg[15:0], o_byte};
                param_cnt_reg <= param_cnt_reg + 2'd1;
              end
            end
            S_RAMWR: begin
              if (!hi_pending_reg) begin
                hi_byte_reg    <= o_byte;
                hi_pending_reg <= 1'b1;
              end else begin
                hi_pending_reg <= 1'b0;
                o_px_x         <= cur_x_reg;
                o_px_y         <= cur_y_reg;
                o_px_data      <= {hi_byte_reg, o_byte};
                o_px_valid     <= 1'b1;
                if (cur_x_reg == ec_reg) begin
                  cur_x_reg <= sc_reg;
                  cur_y_reg <= (cur_y_reg == ep_reg) ? sp_reg : cur_y_reg + 16'd1;
                end else begin
                  cur_x_reg <= cur_x_reg + 16'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Bench for spi_lcd_rx: drives SPI bytes, keeps a window/pixel-index model of
// the panel, and checks every output pulse against it.
module tb_spi_lcd_rx;

  logic        clk = 1'b0;
  logic        rst, sclk, mosi, cs_n, dc;
  logic [7:0]  o_byte, o_cmd;
  logic        o_byte_dc, o_byte_valid, o_cmd_valid, o_px_valid, o_err;
  logic [15:0] o_px_x, o_px_y, o_px_data;

  spi_lcd_rx #(.WIDTH(320), .HEIGHT(240)) dut (
    .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_mosi(mosi), .i_cs_n(cs_n), .i_dc(dc),
    .o_byte(o_byte), .o_byte_dc(o_byte_dc), .o_byte_valid(o_byte_valid),
    .o_cmd(o_cmd), .o_cmd_valid(o_cmd_valid),
    .o_px_x(o_px_x), .o_px_y(o_px_y), .o_px_data(o_px_data), .o_px_valid(o_px_valid),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int edge8_cyc = 0;
  int err_exp = 0;
  int err_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0]  byte_q[$];
  logic [7:0]  cmd_q[$];
  logic [47:0] px_q[$];

  // Model: mode 0 idle, 1 column window, 2 row window, 3 pixel stream
  int         m_mode;
  int         m_np;
  logic [7:0] m_par[4];
  int         m_sc, m_ec, m_sp, m_ep;
  int         m_n;
  logic       m_have_hi;
  logic [7:0] m_hi;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_np = 0; m_n = 0; m_have_hi = 1'b0; m_hi = 8'd0;
    m_sc = 0; m_ec = 319; m_sp = 0; m_ep = 239;
  endtask

  task automatic model_byte(input logic d, input logic [7:0] v);
    int s, e, lim, w, h, x, y;
    byte_q.push_back({d, v});
    if (!d) begin
      cmd_q.push_back(v);
      m_np = 0; m_n = 0; m_have_hi = 1'b0;
      m_mode = (v == 8'h2A) ? 1 : (v == 8'h2B) ? 2 : (v == 8'h2C) ? 3 : 0;
    end else if (m_mode == 1 || m_mode == 2) begin
      m_par[m_np] = v;
      m_np++;
      if (m_np == 4) begin
        s = {m_par[0], m_par[1]};
        e = {m_par[2], m_par[3]};
        lim = (m_mode == 1) ? 320 : 240;
        if (s <= e && e < lim) begin
          if (m_mode == 1) begin m_sc = s; m_ec = e; end
          else begin m_sp = s; m_ep = e; end
        end else begin
          err_exp++;
        end
        m_mode = 0;
      end
    end else if (m_mode == 3) begin
      if (!m_have_hi) begin
        m_hi = v; m_have_hi = 1'b1;
      end else begin
        // Pixel n of the stream lands at raster position n within the window
        w = m_ec - m_sc + 1;
        h = m_ep - m_sp + 1;
        x = m_sc + (m_n % w);
        y = m_sp + ((m_n / w) % h);
        px_q.push_back({16'(x), 16'(y), m_hi, v});
        m_n++;
        m_have_hi = 1'b0;
      end
    end
  endtask

  task automatic spi_bits(input logic d, input logic [7:0] v, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sclk = 1'b0; mosi = v[7-i]; dc = d;
      repeat (3) @(negedge clk);
      sclk = 1'b1;
      if (i == 7) begin
        edge8_cyc = cyc;
        model_byte(d, v);
      end
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    sclk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input logic d, input logic [7:0] v);
    spi_bits(d, v, 8);
  endtask

  task automatic send4(input logic [7:0] cmd, input logic [31:0] p);
    send(1'b0, cmd);
    for (int i = 3; i >= 0; i--) send(1'b1, p[i*8 +: 8]);
  endtask

  task automatic pixel(input logic [15:0] v);
    send(1'b1, v[15:8]);
    send(1'b1, v[7:0]);
  endtask

  // Single compare process: every pulse must match the next model expectation
  logic prev_cmd_byte = 1'b0;
  logic prev_data_byte = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_cmd_byte  = 1'b0;
      prev_data_byte = 1'b0;
    end else begin
      if (o_byte_valid) begin
        check("byte_expected", 48'(byte_q.size() > 0), 48'd1);
        if (byte_q.size() > 0) begin
          check("byte_value", 48'({o_byte_dc, o_byte}), 48'(byte_q.pop_front()));
          check("byte_latency", 48'(cyc - edge8_cyc), 48'd3);
        end
      end
      if (o_cmd_valid) begin
        check("cmd_timing", 48'(prev_cmd_byte), 48'd1);
        check("cmd_expected", 48'(cmd_q.size() > 0), 48'd1);
        if (cmd_q.size() > 0) check("cmd_value", 48'(o_cmd), 48'(cmd_q.pop_front()));
      end
      if (o_px_valid) begin
        check("px_timing", 48'(prev_data_byte), 48'd1);
        check("px_expected", 48'(px_q.size() > 0), 48'd1);
        if (px_q.size() > 0) check("px_value", {o_px_x, o_px_y, o_px_data}, px_q.pop_front());
      end
      if (o_err) begin
        err_seen++;
        check("err_expected", 48'(err_exp > 0), 48'd1);
        if (err_exp > 0) err_exp--;
      end
      prev_cmd_byte  = o_byte_valid & ~o_byte_dc;
      prev_data_byte = o_byte_valid & o_byte_dc;
    end
  end

  task automatic check_all_zero(input string name);
    check(name, {o_byte, o_byte_dc, o_byte_valid, o_cmd, o_cmd_valid, o_px_valid, o_err, 20'd0}, 48'd0);
    check({name, "_px"}, {o_px_x, o_px_y, o_px_data}, 48'd0);
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; dc = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    cs_n = 1'b0;
    repeat (3) @(negedge clk);

    // Single command byte, latency and literal values
    send(1'b0, 8'hA5);
    repeat (3) @(negedge clk);
    check("t1_byte", 48'({o_byte_dc, o_byte}), 48'h0A5);
    check("t1_cmd", 48'(o_cmd), 48'hA5);

    // 3x2 window, seven pixels; the seventh wraps to the origin
    send4(8'h2A, 32'h000A_000C);
    send4(8'h2B, 32'h0005_0006);
    send(1'b0, 8'h2C);
    for (int i = 0; i < 7; i++) pixel(16'hF800 + 16'(i));
    repeat (3) @(negedge clk);
    check("t2_wrap_px", {o_px_x, o_px_y, o_px_data}, {16'd10, 16'd5, 16'hF806});

    // Rejected windows keep the previous one
    send4(8'h2A, 32'h0020_0010);
    send4(8'h2A, 32'h0000_0140);
    repeat (3) @(negedge clk);
    check("t3_err_count", 48'(err_seen), 48'd2);
    send(1'b0, 8'h2C);
    pixel(16'h1234);
    repeat (3) @(negedge clk);
    check("t3_origin_px", {o_px_x, o_px_y, o_px_data}, {16'd10, 16'd5, 16'h1234});

    // Single-column window at the last valid column
    send4(8'h2A, 32'h013F_013F);
    send(1'b0, 8'h2C);
    pixel(16'hAAAA);
    pixel(16'hBBBB);
    repeat (3) @(negedge clk);
    check("t3_edge_px", {o_px_x, o_px_y, o_px_data}, {16'd319, 16'd6, 16'hBBBB});

    // CS raised after 5 bits: partial byte must vanish
    spi_bits(1'b0, 8'hFF, 5);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    cs_n = 1'b0;
    repeat (3) @(negedge clk);
    send(1'b0, 8'h3C);
    repeat (3) @(negedge clk);
    check("t4_byte", 48'(o_byte), 48'h3C);

    // Orphan high byte dropped by a new RAMWR
    send(1'b0, 8'h2C);
    send(1'b1, 8'hAB);
    send(1'b0, 8'h2C);
    pixel(16'h5566);
    repeat (3) @(negedge clk);
    check("t5_px", {o_px_x, o_px_y, o_px_data}, {16'd319, 16'd5, 16'h5566});

    // Reset during a pixel stream
    send4(8'h2A, 32'h0000_0001);
    send(1'b0, 8'h2C);
    for (int i = 0; i < 3; i++) pixel(16'h0100 + 16'(i));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("t6_in_reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send(1'b1, 8'h11);
    send(1'b1, 8'h22);
    send(1'b0, 8'h2C);
    pixel(16'h7788);
    repeat (3) @(negedge clk);
    check("t6_first_px", {o_px_x, o_px_y, o_px_data}, {16'd0, 16'd0, 16'h7788});
    pixel(16'h0001);
    pixel(16'h0002);
    repeat (3) @(negedge clk);
    check("t6_window_px", {o_px_x, o_px_y, o_px_data}, {16'd2, 16'd0, 16'h0002});

    repeat (10) @(negedge clk);
    check("left_bytes", 48'(byte_q.size()), 48'd0);
    check("left_cmds", 48'(cmd_q.size()), 48'd0);
    check("left_px", 48'(px_q.size()), 48'd0);
    check("left_err", 48'(err_exp), 48'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
